data_store_buffer: RTL and testbench

Write buffer between the EX/MEM pipeline register and the data memory. Pipeline stores are queued here and retired to memory in cycles when the pipeline is not using the memory port. Loads are checked against pending stores: an exact-address match is forwarded from the buffer, and a partial overlap stalls the pipeline until the conflicting stores have drained. The memory-side port connects one-to-one to the data memory's Address/WriteData/MemRead/MemWrite/ReadData.

---
 rtl/data_store_buffer.sv | 117 +++++++++++
 tb/tb_data_store_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_store_buffer.sv
// Store buffer between the EX/MEM pipeline register and data memory: queues stores,
// retires them on free memory-port cycles, forwards exact-address loads, stalls partial overlaps.
module data_store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Stall,
  output logic                  Empty,
  output logic                  Full,
  output logic [ADDR_WIDTH-1:0] DM_Address,
  output logic [DATA_WIDTH-1:0] DM_WriteData,
  output logic                  DM_MemRead,
  output logic                  DM_MemWrite,
  input  logic [DATA_WIDTH-1:0] DM_ReadData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] entry_addr [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data [DEPTH];
  logic [PTR_W-1:0]      head, tail;
  logic [CNT_W-1:0]      count;

  logic             store_req, drain, hit, exact, fwd;
  logic [PTR_W-1:0] hit_idx;

  // Two byte ranges of SPAN bytes overlap when either modular distance is below SPAN.
  function automatic logic overlaps(input logic [ADDR_WIDTH-1:0] a, input logic [ADDR_WIDTH-1:0] l);
    logic [ADDR_WIDTH-1:0] d_la, d_al;
    d_la = l - a;
    d_al = a - l;
    return (d_la < SPAN) || (d_al < SPAN);
  endfunction

  assign Empty = (count == '0);
  assign Full  = (count == CNT_W'(DEPTH));

  // Scan oldest to youngest so the last match seen is the youngest overlapping entry.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit     = 1'b0;
    hit_idx = head;
    idx     = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && overlaps(entry_addr[idx], Address)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  // A simultaneous read and write is a load; the store half is dropped.
  assign store_req = MemWrite & ~MemRead;
  assign exact     = hit && (entry_addr[hit_idx] == Address);
  assign fwd       = MemRead & hit & exact;
  assign Stall     = MemRead & hit & ~exact;

  // Gated by reset so pending stores are discarded without touching memory.
  assign drain = ~reset & ~Empty &
                 ((~MemRead & ~MemWrite) | (store_req & Full) | Stall);

  always_comb begin
    ReadData = '0;
    if (fwd)
      ReadData = entry_data[hit_idx];
    else if (MemRead && !hit)
      ReadData = DM_ReadData;
  end

  // A forwarded load needs no memory access, so the read strobe is suppressed too.
  always_comb begin
    DM_Address  = Address;
    DM_MemRead  = MemRead & ~Stall & ~fwd;
    DM_MemWrite = 1'b0;
    if (drain) begin
      DM_Address  = entry_addr[head];
      DM_MemRead  = 1'b0;
      DM_MemWrite = 1'b1;
    end
  end

  assign DM_WriteData = entry_data[head];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (store_req) tail <= tail + 1'b1;
      if (drain)     head <= head + 1'b1;
      count <= count + CNT_W'(store_req) - CNT_W'(drain);
    end
  end

  // NOTE: entry storage is not reset; count alone defines which entries are valid.
  always_ff @(posedge clock) begin
    if (store_req && !reset) begin
      entry_addr[tail] <= Address;
      entry_data[tail] <= WriteData;
    end
  end

endmodule

// File: tb/tb_data_store_buffer.sv
// Directed bench for data_store_buffer: a byte-addressed big-endian data memory model
// plus a table of per-cycle vectors and hand sequences for reset with pending stores.
module tb_data_store_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [7:0]  Address;
  logic [63:0] WriteData, ReadData;
  logic        Stall, Empty, Full;
  logic [7:0]  DM_Address;
  logic [63:0] DM_WriteData, DM_ReadData;
  logic        DM_MemRead, DM_MemWrite;

  int n_pass  = 0;
  int n_total = 0;

  data_store_buffer dut (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .Empty(Empty), .Full(Full),
    .DM_Address(DM_Address), .DM_WriteData(DM_WriteData),
    .DM_MemRead(DM_MemRead), .DM_MemWrite(DM_MemWrite), .DM_ReadData(DM_ReadData)
  );

  always #5 clock = ~clock;

  // Data memory: byte i initialised to {2{i[6:3]}}, so 16..23 = 0x22 and 80..87 = 0xAA.
  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= {2{i[6:3]}};
      mem_ready <= 1'b1;
    end else if (DM_MemWrite) begin
      for (int k = 0; k < 8; k++) mem[DM_Address + 8'(k)] <= DM_WriteData[63-8*k -: 8];
    end
  end

  always_comb begin
    DM_ReadData = '0;
    for (int k = 0; k < 8; k++) DM_ReadData[63-8*k -: 8] = mem[DM_Address + 8'(k)];
  end

  function automatic logic [63:0] word_at(input logic [7:0] a);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[63-8*k -: 8] = mem[a + 8'(k)];
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic rd, wr;
    logic [7:0] addr;
    logic [63:0] wd;
    logic [63:0] e_rdata;
    logic e_stall, e_empty, e_full;
    logic [7:0] e_dm_addr;
    logic e_dm_wr, e_dm_rd;
    logic chk_wd;
    logic [63:0] e_dm_wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [7:0] a,
                              input logic [63:0] wd, input logic [63:0] rdat,
                              input logic st, input logic em, input logic fu,
                              input logic [7:0] da, input logic dw, input logic dr,
                              input logic cw, input logic [63:0] dwd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd; v.e_rdata = rdat;
    v.e_stall = st; v.e_empty = em; v.e_full = fu; v.e_dm_addr = da;
    v.e_dm_wr = dw; v.e_dm_rd = dr; v.chk_wd = cw; v.e_dm_wd = dwd;
    return v;
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [63:0] wd);
    MemRead = rd; MemWrite = wr; Address = a; WriteData = wd;
  endtask

  localparam logic [63:0] D8 = 64'hDEADBEEF00000001;
  localparam logic [63:0] S3 = 64'h0123456789ABCDEF;
  localparam logic [63:0] BV = 64'h0102030405060708;
  localparam logic [63:0] AA = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] A0 = 64'hA0, A1 = 64'hA1, A2 = 64'hA2, A3 = 64'hA3, A4 = 64'hA4;

  initial begin
    //            rd wr addr wdata  rdata                  st em fu dm_a dw dr cw dm_wd
    vecs.push_back(mk(0, 0,   0, 0,  0,                      0, 1, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,  16, 0,  64'h2222222222222222,   0, 1, 0,  16, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1,   8, D8, 0,                      0, 1, 0,   8, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,   8, 0,  D8,                     0, 0, 0,   8, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 0,  0,                      0, 0, 0,   8, 1, 0, 1, D8));
    vecs.push_back(mk(0, 0,   0, 0,  0,                      0, 1, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,  24, S3, 0,                      0, 1, 0,  24, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,  28, 0,  0,                      1, 0, 0,  24, 1, 0, 1, S3));
    vecs.push_back(mk(1, 0,  28, 0,  64'h89ABCDEF44444444,   0, 1, 0,  28, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1,   0, A0, 0,                      0, 1, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,  80, 0,  AA,                     0, 0, 0,  80, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1,  40, A1, 0,                      0, 0, 0,  40, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,  80, 0,  AA,                     0, 0, 0,  80, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1,  48, A2, 0,                      0, 0, 0,  48, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,  80, 0,  AA,                     0, 0, 0,  80, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1,  56, A3, 0,                      0, 0, 0,  56, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,  80, 0,  AA,                     0, 0, 1,  80, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1,  64, A4, 0,                      0, 0, 1,   0, 1, 0, 1, A0));
    vecs.push_back(mk(1, 0,  80, 0,  AA,                     0, 0, 1,  80, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,   0, 0,  0,                      0, 0, 1,  40, 1, 0, 1, A1));
    vecs.push_back(mk(0, 0,   0, 0,  0,                      0, 0, 0,  48, 1, 0, 1, A2));
    vecs.push_back(mk(0, 0,   0, 0,  0,                      0, 0, 0,  56, 1, 0, 1, A3));
    vecs.push_back(mk(0, 0,   0, 0,  0,                      0, 0, 0,  64, 1, 0, 1, A4));
    vecs.push_back(mk(0, 1,  16, 1,  0,                      0, 1, 0,  16, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,  16, 2,  0,                      0, 0, 0,  16, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,  16, 0,  2,                      0, 0, 0,  16, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 0,  0,                      0, 0, 0,  16, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0,   0, 0,  0,                      0, 0, 0,  16, 1, 0, 1, 2));
    vecs.push_back(mk(1, 0,  16, 0,  2,                      0, 1, 0,  16, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 100, BV, 0,                      0, 1, 0, 100, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 108, 0,  64'hDDDDDDDDEEEEEEEE,   0, 0, 0, 108, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0,  93, 0,  0,                      1, 0, 0, 100, 1, 0, 1, BV));
    vecs.push_back(mk(1, 0,  93, 0,  64'hBBBBBBCCCCCCCC01,   0, 1, 0,  93, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 100, '1, BV,                     0, 1, 0, 100, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,   0, 0,  0,                      0, 1, 0,   0, 0, 0, 0, 0));

    reset = 1'b1;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
      @(negedge clock);
      check($sformatf("v%0d.ReadData", i),    ReadData,    vecs[i].e_rdata);
      check($sformatf("v%0d.Stall", i),       64'(Stall),       64'(vecs[i].e_stall));
      check($sformatf("v%0d.Empty", i),       64'(Empty),       64'(vecs[i].e_empty));
      check($sformatf("v%0d.Full", i),        64'(Full),        64'(vecs[i].e_full));
      check($sformatf("v%0d.DM_Address", i),  64'(DM_Address),  64'(vecs[i].e_dm_addr));
      check($sformatf("v%0d.DM_MemWrite", i), 64'(DM_MemWrite), 64'(vecs[i].e_dm_wr));
      check($sformatf("v%0d.DM_MemRead", i),  64'(DM_MemRead),  64'(vecs[i].e_dm_rd));
      if (vecs[i].chk_wd)
        check($sformatf("v%0d.DM_WriteData", i), DM_WriteData, vecs[i].e_dm_wd);
      @(posedge clock);
      #1;
    end

    // Three pending stores, then reset while the port is idle (drain would otherwise fire).
    for (int j = 0; j < 3; j++) begin
      drive(0, 1, 8'(200 + 8 * j), 64'h5A5A0000 + 64'(j));
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    drive(0, 0, 0, 0);
    @(negedge clock);
    check("rst.pending_not_empty", 64'(Empty), 64'd0);
    check("rst.no_dm_write", 64'(DM_MemWrite), 64'd0);
    @(posedge clock);
    #1;
    drive(0, 1, 232, 64'h1234);
    @(negedge clock);
    check("rst.empty_after_edge", 64'(Empty), 64'd1);
    check("rst.full_after_edge", 64'(Full), 64'd0);
    check("rst.stall_after_edge", 64'(Stall), 64'd0);
    check("rst.store_no_dm_write", 64'(DM_MemWrite), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    drive(0, 0, 0, 0);
    @(negedge clock);
    check("rst.store_not_queued", 64'(Empty), 64'd1);
    check("rst.idle_no_dm_write", 64'(DM_MemWrite), 64'd0);
    @(posedge clock);
    #1;

    check("mem.200", word_at(200), 64'h9999999999999999);
    check("mem.208", word_at(208), 64'hAAAAAAAAAAAAAAAA);
    check("mem.216", word_at(216), 64'hBBBBBBBBBBBBBBBB);
    check("mem.232", word_at(232), 64'hDDDDDDDDDDDDDDDD);
    check("mem.8",   word_at(8),   D8);
    check("mem.24",  word_at(24),  S3);
    check("mem.0",   word_at(0),   A0);
    check("mem.40",  word_at(40),  A1);
    check("mem.64",  word_at(64),  A4);
    check("mem.16",  word_at(16),  64'd2);
    check("mem.100", word_at(100), BV);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
